// File: rtl/hpgp_turbo_itl_pp_if.sv
// Symbol-stream bundle for the ping-pong turbo interleaver: input beats with
// frame config, output symbols with last marker, ready in each direction.
interface hpgp_turbo_itl_pp_if #(
  parameter int SYM_W = 2
) ();
  logic [1:0]       pb_size;
  logic             itl_mode;
  logic [SYM_W-1:0] din;
  logic             din_vld;
  logic             din_rdy;
  logic [SYM_W-1:0] dout;
  logic             dout_vld;
  logic             dout_last;
  logic             out_rdy;

  modport master (
    output pb_size, itl_mode, din, din_vld, out_rdy,
    input  din_rdy, dout, dout_vld, dout_last
  );

  modport slave (
    input  pb_size, itl_mode, din, din_vld, out_rdy,
    output din_rdy, dout, dout_vld, dout_last
  );
endinterface

// File: rtl/hpgp_turbo_itl_pp.sv
// Ping-pong turbo interleaver/deinterleaver: one bank fills while the other drains,
// permutation pi(k) = (OFF + k*P) mod L generated incrementally.
module hpgp_turbo_itl_pp #(
  parameter int SYM_W  = 2,
  parameter int ADDR_W = 12,
  parameter int L0 = 64,  parameter int L1 = 544, parameter int L2 = 2080, parameter int L3 = 8,
  parameter int P0 = 13,  parameter int P1 = 37,  parameter int P2 = 139,  parameter int P3 = 3,
  parameter int OFF0 = 0, parameter int OFF1 = 0, parameter int OFF2 = 0,  parameter int OFF3 = 1
) (
  input  logic clk,
  input  logic rst,
  hpgp_turbo_itl_pp_if.slave bus
);

  localparam int AW1   = ADDR_W + 1;
  localparam int DEPTH = 2 ** AW1;

  typedef logic [ADDR_W:0]   sum_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic { W_IDLE, W_FILL }  wstate_e;
  typedef enum logic { R_IDLE, R_DRAIN } rstate_e;

  function automatic sum_t len_of(input logic [1:0] sz);
    case (sz)
      2'd0:    return AW1'(L0);
      2'd1:    return AW1'(L1);
      2'd2:    return AW1'(L2);
      default: return AW1'(L3);
    endcase
  endfunction

  function automatic sum_t step_of(input logic [1:0] sz);
    case (sz)
      2'd0:    return AW1'(P0);
      2'd1:    return AW1'(P1);
      2'd2:    return AW1'(P2);
      default: return AW1'(P3);
    endcase
  endfunction

  function automatic addr_t off_of(input logic [1:0] sz);
    case (sz)
      2'd0:    return ADDR_W'(OFF0);
      2'd1:    return ADDR_W'(OFF1);
      2'd2:    return ADDR_W'(OFF2);
      default: return ADDR_W'(OFF3);
    endcase
  endfunction

  // One modular step of the permutation; acc < L and P < L, so one subtract suffices.
  function automatic addr_t pi_next(input addr_t acc, input logic [1:0] sz);
    sum_t s;
    s = {1'b0, acc} + step_of(sz);
    if (s >= len_of(sz)) s = s - len_of(sz);
    return s[ADDR_W-1:0];
  endfunction

  wstate_e          wst_q, wst_d;
  addr_t            k_q, k_d, wacc_q, wacc_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic [1:0]       cfg_sz_q [2];
  logic             cfg_mode_q [2];

  rstate_e          rdst_q, rdst_d;
  addr_t            j_q, j_d, racc_q, racc_d;
  logic             rd_bank_q, rd_bank_d;
  logic [SYM_W-1:0] dout_q;
  logic             dout_vld_q, dout_vld_d, dout_last_q, dout_last_d;

  logic [SYM_W-1:0] mem_q [DEPTH];

  logic       din_rdy, w_acc, w_mode, w_last;
  logic [1:0] w_sz, r_sz;
  addr_t      w_pi, w_addr, r_addr;
  logic       r_mode, r_adv, r_issue, r_last;

  // The first beat of a frame takes its config straight from the inputs.
  assign din_rdy = !rst && !bank_full_q[wr_bank_q];
  assign w_acc   = bus.din_vld && din_rdy;
  assign w_sz    = (wst_q == W_IDLE) ? bus.pb_size  : cfg_sz_q[wr_bank_q];
  assign w_mode  = (wst_q == W_IDLE) ? bus.itl_mode : cfg_mode_q[wr_bank_q];
  assign w_pi    = (wst_q == W_IDLE) ? off_of(bus.pb_size) : wacc_q;
  assign w_addr  = w_mode ? w_pi : k_q;
  assign w_last  = (({1'b0, k_q} + sum_t'(1)) == len_of(w_sz));

  assign r_sz    = cfg_sz_q[rd_bank_q];
  assign r_mode  = cfg_mode_q[rd_bank_q];
  assign r_addr  = r_mode ? j_q : racc_q;
  assign r_adv   = !dout_vld_q || bus.out_rdy;
  assign r_issue = (rdst_q == R_DRAIN) && r_adv;
  assign r_last  = (({1'b0, j_q} + sum_t'(1)) == len_of(r_sz));

  always_comb begin
    wst_d       = wst_q;
    k_d         = k_q;
    wacc_d      = wacc_q;
    wr_bank_d   = wr_bank_q;
    bank_full_d = bank_full_q;
    rdst_d      = rdst_q;
    j_d         = j_q;
    racc_d      = racc_q;
    rd_bank_d   = rd_bank_q;
    dout_vld_d  = dout_vld_q;
    dout_last_d = dout_last_q;

    if (w_acc) begin
      if (w_last) begin
        k_d                    = '0;
        wst_d                  = W_IDLE;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end else begin
        k_d    = k_q + addr_t'(1);
        wacc_d = pi_next(w_pi, w_sz);
        wst_d  = W_FILL;
      end
    end

    // Releasing the drained bank on the last handshake; the writer only sees it next cycle.
    if (dout_vld_q && bus.out_rdy && dout_last_q) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end

    if (r_adv) begin
      dout_vld_d  = r_issue;
      dout_last_d = r_issue && r_last;
    end

    case (rdst_q)
      R_IDLE: begin
        if (bank_full_q[rd_bank_q] && !(dout_vld_q && dout_last_q)) begin
          rdst_d = R_DRAIN;
          j_d    = '0;
          racc_d = off_of(r_sz);
        end
      end
      R_DRAIN: begin
        if (r_issue) begin
          if (r_last) begin
            rdst_d = R_IDLE;
            j_d    = '0;
          end else begin
            j_d    = j_q + addr_t'(1);
            racc_d = pi_next(racc_q, r_sz);
          end
        end
      end
      default: rdst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wst_q       <= W_IDLE;
      k_q         <= '0;
      wacc_q      <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= '0;
      rdst_q      <= R_IDLE;
      j_q         <= '0;
      racc_q      <= '0;
      rd_bank_q   <= 1'b0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
    end else begin
      wst_q       <= wst_d;
      k_q         <= k_d;
      wacc_q      <= wacc_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      rdst_q      <= rdst_d;
      j_q         <= j_d;
      racc_q      <= racc_d;
      rd_bank_q   <= rd_bank_d;
      dout_vld_q  <= dout_vld_d;
      dout_last_q <= dout_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          dout_q <= '0;
    else if (r_issue) dout_q <= mem_q[{rd_bank_q, r_addr}];
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      mem_q[{wr_bank_q, w_addr}] <= bus.din;
      if (wst_q == W_IDLE) begin
        cfg_sz_q[wr_bank_q]   <= bus.pb_size;
        cfg_mode_q[wr_bank_q] <= bus.itl_mode;
      end
    end
  end

  assign bus.din_rdy   = din_rdy;
  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.dout_last = dout_last_q;

endmodule
